// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: both read ports, the byte-strobed write port
// and the bulk-clear control/status signals. clk and reset are plain ports
// on the register file itself.
interface regfile_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NBYTES = DATA_W / 8;

    logic [ADDR_W-1:0] ridx_a;
    logic [ADDR_W-1:0] ridx_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [ADDR_W-1:0] widx;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [NBYTES-1:0] wstrb;
    logic              clr_start;
    logic              busy;
    logic              wr_drop;

    // Client side: issues reads, writes and clear requests.
    modport master (
        output ridx_a, ridx_b, widx, wdata, we, wstrb, clr_start,
        input  rdata_a, rdata_b, busy, wr_drop
    );

    // Register file side.
    modport slave (
        input  ridx_a, ridx_b, widx, wdata, we, wstrb, clr_start,
        output rdata_a, rdata_b, busy, wr_drop
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with byte strobes, write-first bypass
// and a sequenced bulk-clear engine.
// Optional macro REGFILE_ZERO_REG_EN: entry 0 is hardwired to zero.
// The interface instance must use the same DATA_W/ADDR_W as this module.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal operation, writes and bypass allowed
// SWEEP | clearing entry[cnt] each cycle, writes rejected (wr_drop)
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic           clk,
    input logic           reset,
    regfile_2r1w_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              wr_zero;
    logic              wr_en;
    logic              drop_nxt;
    logic              wr_drop_q;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Lanes with strb set come from nw, the rest keep old.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] nw,
        input logic [NBYTES-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int k = 0; k < NBYTES; k++) begin
            if (strb[k]) res[8*k +: 8] = nw[8*k +: 8];
        end
        return res;
    endfunction

    assign busy = (state == SWEEP);

`ifdef REGFILE_ZERO_REG_EN
    assign wr_zero = (bus.widx == '0);
`else
    assign wr_zero = 1'b0;
`endif

    // A write to the zero register is silently discarded, never counted as a drop.
    assign wr_en    = bus.we && !busy && !wr_zero;
    assign drop_nxt = bus.we && busy && (|bus.wstrb) && !wr_zero;

    // Clear FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Clear FSM next state: the sweep ends after entry DEPTH-1 is cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clr_start) state_nxt = SWEEP;
            SWEEP:   if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep pointer; wraps back to 0 naturally on the final increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           cnt <= '0;
        else if (!busy && bus.clr_start)     cnt <= '0;
        else if (busy)                       cnt <= cnt + ADDR_W'(1);
    end

    // Storage: sweep clears take the port while busy, otherwise strobed writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            mem[bus.widx] <= lane_merge(mem[bus.widx], bus.wdata, bus.wstrb);
        end
    end

    // One-cycle pulse flagging a write rejected by an active sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_drop_q <= 1'b0;
        else       wr_drop_q <= drop_nxt;
    end

    // Combinational reads with write-first bypass on each port.
    always_comb begin
        rd_a = mem[bus.ridx_a];
        rd_b = mem[bus.ridx_b];
        if (wr_en && (bus.widx == bus.ridx_a)) rd_a = lane_merge(rd_a, bus.wdata, bus.wstrb);
        if (wr_en && (bus.widx == bus.ridx_b)) rd_b = lane_merge(rd_b, bus.wdata, bus.wstrb);
`ifdef REGFILE_ZERO_REG_EN
        if (bus.ridx_a == '0) rd_a = '0;
        if (bus.ridx_b == '0) rd_b = '0;
`endif
    end

    assign bus.rdata_a = rd_a;
    assign bus.rdata_b = rd_b;
    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: stimulus pushes expected outputs from
// an array-based reference model, a negedge monitor pops and compares.
module tb_regfile_2r1w;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        drop;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: plain array plus sweep progress.
    logic [31:0] m_mem [32];
    bit          m_sweep;
    int          m_pos;
    bit          m_drop;

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    function automatic bit is_zero_reg(input logic [4:0] idx);
`ifdef REGFILE_ZERO_REG_EN
        return idx == 5'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic w, input logic [4:0] wi,
                                           input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] v;
        if (is_zero_reg(idx)) return 32'd0;
        v = m_mem[idx];
        if (w && !m_sweep && wi == idx) v = lane_merge(v, wd, ws);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rdata_a", bus.rdata_a, e.a);
            chk("rdata_b", bus.rdata_b, e.b);
            chk("busy", {31'd0, bus.busy}, {31'd0, e.busy});
            chk("wr_drop", {31'd0, bus.wr_drop}, {31'd0, e.drop});
        end
    end

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wi,
                        input logic [31:0] wd, input logic w, input logic [3:0] ws, input logic cs);
        exp_t e;
        bit   wz;
        bus.ridx_a = ra; bus.ridx_b = rb; bus.widx = wi; bus.wdata = wd;
        bus.we = w; bus.wstrb = ws; bus.clr_start = cs;
        e.a = m_read(ra, w, wi, wd, ws);
        e.b = m_read(rb, w, wi, wd, ws);
        e.busy = m_sweep;
        e.drop = m_drop;
        exp_q.push_back(e);
        @(posedge clk);
        wz = is_zero_reg(wi);
        m_drop = m_sweep && w && (ws != 4'd0) && !wz;
        if (!m_sweep && w && !wz) m_mem[wi] = lane_merge(m_mem[wi], wd, ws);
        if (m_sweep) begin
            m_mem[m_pos] = 32'd0;
            m_pos++;
            if (m_pos == 32) begin
                m_sweep = 1'b0;
                m_pos = 0;
            end
        end else if (cs) begin
            m_sweep = 1'b1;
            m_pos = 0;
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
        step(ra, rb, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [4:0] wi, input logic [31:0] wd, input logic [3:0] ws);
        step(5'($urandom), 5'($urandom), wi, wd, 1'b1, ws, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i));
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        exp_t e;
        bus.we = 1'b0; bus.clr_start = 1'b0; bus.wstrb = 4'd0;
        bus.ridx_a = 5'd0; bus.ridx_b = 5'd31; bus.widx = 5'd0; bus.wdata = 32'd0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_sweep = 1'b0; m_pos = 0; m_drop = 1'b0;
        #1;
        e.a = 32'd0; e.b = 32'd0; e.busy = 1'b0; e.drop = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i + 100), 4'hF);
    endtask

    initial begin
        bus.ridx_a = '0; bus.ridx_b = '0; bus.widx = '0; bus.wdata = '0;
        bus.we = 1'b0; bus.wstrb = '0; bus.clr_start = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        read_all();

        // Basic write/read.
        wr(5'd1, 32'd11, 4'hF);
        wr(5'd2, 32'd240, 4'hF);
        idle_read(5'd1, 5'd2);
        read_all();

        // Byte strobe with same-cycle bypass on both ports.
        wr(5'd3, 32'hAABBCCDD, 4'hF);
        step(5'd3, 5'd3, 5'd3, 32'h11223344, 1'b1, 4'b0101, 1'b0);
        idle_read(5'd3, 5'd3);
        wr(5'd3, 32'hFFFFFFFF, 4'd0);
        idle_read(5'd3, 5'd4);

        // Bulk clear with a rejected write mid-sweep.
        fill();
        step(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 4'd0, 1'b1);
        for (int c = 0; c < 36; c++) begin
            if (c == 10)      step(5'd5, 5'd5, 5'd5, 32'd7, 1'b1, 4'hF, 1'b0);
            else if (c == 15) step(5'd31, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b1);
            else              idle_read(5'($urandom), 5'($urandom));
        end
        read_all();

        // Reset in the middle of a sweep.
        fill();
        step(5'd9, 5'd20, 5'd0, 32'd0, 1'b0, 4'd0, 1'b1);
        for (int c = 0; c < 10; c++) idle_read(5'($urandom), 5'($urandom));
        do_reset();
        read_all();
        wr(5'd9, 32'd55, 4'hF);
        idle_read(5'd9, 5'd9);

        // Entry 0 behaviour (hardwired zero only with the macro).
        step(5'd0, 5'd0, 5'd0, 32'd10, 1'b1, 4'hF, 1'b0);
        idle_read(5'd0, 5'd1);
        idle_read(5'd0, 5'd0);

        // Random traffic with occasional clears.
        for (int n = 0; n < 600; n++) begin
            step(5'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'($urandom),
                 4'($urandom), ($urandom_range(39, 0) == 0));
        end
        for (int n = 0; n < 40; n++) idle_read(5'($urandom), 5'($urandom));
        read_all();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the single-read-port register file.
- Provides DEPTH = 2**ADDR_W entries of DATA_W bits with two independent combinational read ports and one byte-strobed synchronous write port.
- Write-to-read bypass makes same-cycle writes visible on the read ports.
- A sequenced bulk-clear engine zeroes all entries on request without asserting reset.
- Sits in the datapath as the operand store for the ALU/controller blocks.

Parameters:
- DATA_W, 32, entry width in bits; must be a multiple of 8.
- ADDR_W, 5, index width; DEPTH = 2**ADDR_W.
- NBYTES, DATA_W/8, derived local parameter; not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ridx_a  input  ADDR_W  read index, port A
- ridx_b  input  ADDR_W  read index, port B
- rdata_a  output  DATA_W  read data, port A (combinational)
- rdata_b  output  DATA_W  read data, port B (combinational)
- widx  input  ADDR_W  write index
- wdata  input  DATA_W  write data
- we  input  1  write enable
- wstrb  input  NBYTES  byte-lane enables; bit k covers wdata[8k+7:8k]
- clr_start  input  1  single-cycle request to start a bulk clear
- busy  output  1  high while the bulk clear is in progress
- wr_drop  output  1  registered one-cycle pulse: a write was rejected because busy was high

Behaviour:
- Reset (async, active-high):
  - every entry goes to 0; busy=0, wr_drop=0, FSM=IDLE, clear counter=0;
  - rdata_a/rdata_b then read 0 for all indices;
  - reset asserted mid-sweep aborts the sweep immediately.
- Write:
  - on posedge clk, when we=1 and busy=0, entry[widx] byte k <= wdata byte k for each wstrb[k]=1;
  - bytes with wstrb[k]=0 are unchanged;
  - we=1 with wstrb=0 is a no-op, no drop.
- Read: rdata_x = entry[ridx_x], combinational, zero-cycle latency.
- Bypass (write-first):
  - applies when we=1, busy=0 and widx==ridx_x;
  - rdata_x = byte-merge of wdata (strobed lanes) over entry[ridx_x] (other lanes);
  - applies independently to both ports, including ridx_a==ridx_b==widx.
- Clear FSM, states IDLE and SWEEP:
  - IDLE --clr_start--> SWEEP; counter <= 0 and busy=1 from the next cycle.
  - SWEEP: each cycle entry[counter] <= 0 and counter increments; exactly DEPTH cycles.
  - After clearing entry DEPTH-1, return to IDLE with busy=0 on the following cycle; the counter wraps to 0 and does not overflow.
  - clr_start while in SWEEP is ignored; the sweep does not restart.
  - clr_start and we in the same IDLE cycle: the write commits, then the sweep later clears it.
- Writes while busy=1:
  - not performed;
  - no bypass;
  - wr_drop=1 on the next cycle.
- Reads while busy=1 return current array contents: cleared entries read 0, entries not yet cleared read old data.
- Index arithmetic is unsigned ADDR_W bits; every index is in range by construction.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - entry 0 is hardwired to 0: writes to widx=0 are discarded silently (no wr_drop);
  - reads of index 0 always return 0;
  - bypass never applies to index 0.
- Undefined: entry 0 is an ordinary storage entry.

Test Plan:
- Reset state: assert reset, release, sweep ridx_a over 0..31 -> rdata_a=0 for all indices; busy=0, wr_drop=0.
- Basic write/read: write widx=1, wdata=11, wstrb=4'hF, then widx=2, wdata=240 -> ridx_a=1 gives 11, ridx_b=2 gives 240; all other indices give 0.
- Byte strobe and bypass:
  - entry 3 = 32'hAABBCCDD;
  - same cycle: we=1, widx=3, wdata=32'h11223344, wstrb=4'b0101, ridx_a=ridx_b=3;
  - required: rdata_a = rdata_b = 32'hAA22CC44 in that cycle, and entry 3 holds 32'hAA22CC44 after the edge.
- Bulk clear:
  - fill entries 0..31 with value i+100, pulse clr_start;
  - busy is high for exactly 32 cycles;
  - write widx=5, wdata=7 mid-sweep -> no update and a one-cycle wr_drop pulse;
  - after busy falls, every entry reads 0.
- Reset mid-sweep: assert reset 10 cycles into the sweep -> busy=0 immediately; all entries 0; a subsequent write of 55 to entry 9 reads back 55.
- REGFILE_ZERO_REG_EN defined: write widx=0, wdata=10 -> ridx_a=0 reads 0, including in the same cycle; wr_drop stays 0. Undefined: the same write reads back 10.
